store_rmw_ctrl: RTL

- Sequences sub-word stores (SB/SH) to the word-wide data memory as read-modify-write; word stores (SW) are a direct write.
- Accepts one store request at a time from the CPU memory stage and holds req_ready low while busy, so the CPU can stall.
- Owns the data-memory read/write strobes during a store. Performs the byte/halfword lane merge internally.

---
 rtl/store_rmw_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/store_rmw_ctrl.sv
// Store sequencer for a word-wide data memory: SW writes directly, SB/SH do a
// read-modify-write with the lane merge done here.
//
// state | meaning
// IDLE  | ready for a request, outputs hold last mem_addr/mem_wdata
// READ  | mem_re high for one cycle on the latched word address
// WAIT  | counting down MEM_LAT until mem_rdata is valid, then merge
// WRITE | mem_we/done high with the merged word
// ERR   | misalign_err high for one cycle, no memory access
module store_rmw_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        busy,
  output logic        done,
  output logic        misalign_err,
  output logic [29:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [1:0]  lane_q;
  logic        half_q;
  logic [15:0] wdata_q;
  logic [31:0] merged;
  logic        illegal;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    illegal = 1'b0;
    case (req_size)
      2'b01:   illegal = req_addr[0];
      2'b10:   illegal = (req_addr[1:0] != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // Only the lanes addressed by the store are replaced; the rest come from memory.
  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      lane_q       <= 2'd0;
      half_q       <= 1'b0;
      wdata_q      <= 16'd0;
      mem_addr     <= 30'd0;
      mem_wdata    <= 32'd0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr[31:2];
            lane_q   <= req_addr[1:0];
            half_q   <= req_size[0];
            wdata_q  <= req_wdata[15:0];
            if (illegal) begin
              state        <= ERR;
              misalign_err <= 1'b1;
            end else if (req_size == 2'b10) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              done      <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state  <= READ;
              mem_re <= 1'b1;
            end
          end
        end
        READ: begin
          wait_cnt <= 3'(MEM_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          // Count reaches 1 in the cycle mem_rdata is valid.
          if (wait_cnt == 3'd1) begin
            mem_wdata <= merged;
            mem_we    <= 1'b1;
            done      <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE:   state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
